psum_ofifo: RTL

Output collection buffer downstream of the MAC column array. Each MAC column delivers one signed partial sum per cycle when its `fifo_wr` is high; columns fire staggered in time, so this block keeps one FIFO per column. It presents a column-aligned output word only once every column holds data. Its consumer is the psum SRAM write path / accumulator.

---
 rtl/psum_ofifo_pkg.sv | 15 +
 rtl/psum_fifo_lane.sv | 50 +++++
 rtl/psum_ofifo.sv | 64 ++++++
 3 files changed

// File: rtl/psum_ofifo_pkg.sv
// Shared constants and helpers for the psum output collection buffer.
package psum_ofifo_pkg;

  localparam int unsigned COL         = 8;
  localparam int unsigned BW_PSUM     = 20;
  localparam int unsigned OFIFO_DEPTH = 16;

  // Pointer width carries one extra wrap bit so full and empty can be told apart.
  function automatic int unsigned ptr_width(input int unsigned d);
    return $clog2(d) + 1;
  endfunction

  localparam int unsigned OFIFO_PTR_W = ptr_width(OFIFO_DEPTH);

endpackage

// File: rtl/psum_fifo_lane.sv
// Single-lane circular FIFO holding partial sums from one MAC column.
module psum_fifo_lane
  import psum_ofifo_pkg::*;
#(
  parameter int unsigned bw_psum = BW_PSUM,
  parameter int unsigned depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [bw_psum-1:0] in,
  output logic [bw_psum-1:0] out_head,
  output logic               empty,
  output logic               full
);

  localparam int unsigned pw = ptr_width(depth);
  localparam int unsigned aw = pw - 1;

  logic [pw-1:0]      wr_ptr;
  logic [pw-1:0]      rd_ptr;
  logic [bw_psum-1:0] mem [depth];
  logic               do_wr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
  assign out_head = mem[rd_ptr[aw-1:0]];

  // A concurrent pop frees a slot, so a full lane may still accept this write.
  // rd is only ever asserted by the top when every lane is non-empty.
  assign do_wr = wr && (!full || rd);

  // Pointer update; the wrap bit toggles naturally on overflow of the low bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + {{aw{1'b0}}, 1'b1};
      if (rd)    rd_ptr <= rd_ptr + {{aw{1'b0}}, 1'b1};
    end
  end

  // Storage array, not reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[aw-1:0]] <= in;
  end

endmodule

// File: rtl/psum_ofifo.sv
// Per-column psum FIFOs that release one column-aligned word once every lane has data.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int unsigned col     = COL,
  parameter int unsigned bw_psum = BW_PSUM,
  parameter int unsigned depth   = OFIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col-1:0]           wr,
  input  logic [col*bw_psum-1:0]   in,
  input  logic                     rd,
  output logic [col*bw_psum-1:0]   out,
  output logic                     out_valid,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     o_overflow
);

  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_full;
  logic [col*bw_psum-1:0] lane_head;
  logic                   pop;
  logic                   drop;

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_fifo_lane #(
      .bw_psum (bw_psum),
      .depth   (depth)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr[i]),
      .rd       (pop),
      .in       (in[i*bw_psum +: bw_psum]),
      .out_head (lane_head[i*bw_psum +: bw_psum]),
      .empty    (lane_empty[i]),
      .full     (lane_full[i])
    );
  end

  assign o_valid = &(~lane_empty);
  assign o_full  = |lane_full;
  assign o_ready = ~o_full;
  assign pop     = rd && o_valid;
  // Only a pop in the same cycle can rescue a write to a full lane.
  assign drop    = (|(wr & lane_full)) && !pop;

  // Output word register, one-cycle valid pulse, and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out        <= '0;
      out_valid  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop)  out        <= lane_head;
      if (drop) o_overflow <= 1'b1;
    end
  end

endmodule
